// File: rtl/pbvi_pkg.sv
// Shared PBVI definitions: index/accumulator widths, FSM states, data formats.
// PBVI_VALUE_SAT_EN narrows the reported value to the gamma format.
package pbvi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC,
        ST_CMP,
        ST_EMIT,
        ST_FIN
    } state_t;

    // Belief entries are unsigned Q0.W fractions, gamma entries are signed.
    localparam bit BELIEF_SIGNED = 1'b0;
    localparam bit GAMMA_SIGNED  = 1'b1;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // {0,belief} x gamma needs 2W+1 bits; summing NUM_S terms adds clog2(NUM_S).
    function automatic int acc_w(input int w, input int ns);
        return 2 * w + 1 + $clog2(ns);
    endfunction

    function automatic int value_w(input int w, input int ns);
`ifdef PBVI_VALUE_SAT_EN
        return w + 0 * ns;
`else
        return acc_w(w, ns);
`endif
    endfunction

endpackage

// File: rtl/pbvi_mac.sv
// Signed multiply-accumulate of an unsigned belief entry and a signed gamma
// entry; clear has priority over enable.
module pbvi_mac #(
    parameter int W     = 16,
    parameter int ACC_W = 2 * W + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [W-1:0]            belief,
    input  logic [W-1:0]            gamma,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*W:0] belief_ext;
    logic signed [2*W:0] gamma_ext;
    logic signed [2*W:0] prod;

    // Product magnitude stays below 2^31, so the 2W+1-bit truncation is exact.
    assign belief_ext = {{(W + 1){1'b0}}, belief};
    assign gamma_ext  = {{(W + 1){gamma[W-1]}}, gamma};
    assign prod       = belief_ext * gamma_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(ACC_W - 2 * W - 1){prod[2*W]}}, prod};
        end
    end

endmodule

// File: rtl/pbvi_backup_select.sv
// PBVI backup: per belief point, argmax over actions of belief . gamma[a].
// PBVI_VALUE_SAT_EN reports the winning value shifted back to gamma format, saturated.
//
// state | meaning
// IDLE  | memories writable, waiting for start
// MAC   | one belief x gamma product per cycle for current (b, a)
// CMP   | fold finished dot product into running best
// EMIT  | hold result until out_ready
// FIN   | one-cycle done pulse
module pbvi_backup_select
    import pbvi_pkg::*;
#(
    parameter int NUM_S = 2,
    parameter int NUM_B = 16,
    parameter int NUM_A = 3,
    parameter int W     = 16,
    localparam int SW    = idx_w(NUM_S),
    localparam int BW    = idx_w(NUM_B),
    localparam int AW    = idx_w(NUM_A),
    localparam int ACC_W = acc_w(W, NUM_S),
    localparam int VW    = value_w(W, NUM_S)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_a,
    input  logic [BW-1:0] wr_b,
    input  logic [SW-1:0] wr_s,
    input  logic [W-1:0]  wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_b,
    output logic [AW-1:0] out_action,
    output logic [VW-1:0] out_value
);

    state_t state, state_nxt;

    logic [BW-1:0]           b;
    logic [AW-1:0]           a;
    logic [SW-1:0]           s;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] best_val;
    logic [AW-1:0]           best_act;
    logic                    best_ok;
    logic                    wr_ok, last_s, last_a, last_b;
    logic [W-1:0]            mac_belief, mac_gamma;

    logic [W-1:0] belief_mem [NUM_B][NUM_S];
    logic [W-1:0] gamma_mem  [NUM_A][NUM_B][NUM_S];

    assign busy      = (state == ST_MAC) || (state == ST_CMP) || (state == ST_EMIT);
    assign out_valid = (state == ST_EMIT);
    assign done      = (state == ST_FIN);
    assign out_b      = b;
    assign out_action = best_act;

    assign last_s = (32'(s) == 32'(NUM_S - 1));
    assign last_a = (32'(a) == 32'(NUM_A - 1));
    assign last_b = (32'(b) == 32'(NUM_B - 1));

    // Memories only change outside a sweep; out-of-range indices are dropped.
    assign wr_ok = wr_en && !busy
                && (32'(wr_b) < 32'(NUM_B)) && (32'(wr_s) < 32'(NUM_S))
                && (!wr_sel || (32'(wr_a) < 32'(NUM_A)));

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (wr_sel) begin
                gamma_mem[wr_a][wr_b][wr_s] <= wr_data;
            end else begin
                belief_mem[wr_b][wr_s] <= wr_data;
            end
        end
    end

    assign mac_belief = belief_mem[b][s];
    assign mac_gamma  = gamma_mem[a][b][s];

    pbvi_mac #(.W(W), .ACC_W(ACC_W)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != ST_MAC),
        .en     (state == ST_MAC),
        .belief (mac_belief),
        .gamma  (mac_gamma),
        .acc    (acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_MAC;
            ST_MAC:  if (last_s) state_nxt = ST_CMP;
            ST_CMP:  state_nxt = last_a ? ST_EMIT : ST_MAC;
            ST_EMIT: if (out_ready) state_nxt = last_b ? ST_FIN : ST_MAC;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b        <= '0;
            a        <= '0;
            s        <= '0;
            best_val <= '0;
            best_act <= '0;
            best_ok  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        b       <= '0;
                        a       <= '0;
                        s       <= '0;
                        best_ok <= 1'b0;
                    end
                end
                ST_MAC: s <= last_s ? '0 : s + SW'(1);
                ST_CMP: begin
                    // Strict compare: ties keep the lower action index.
                    if (!best_ok || (acc > best_val)) begin
                        best_val <= acc;
                        best_act <= a;
                        best_ok  <= 1'b1;
                    end
                    a <= last_a ? '0 : a + AW'(1);
                    s <= '0;
                end
                ST_EMIT: begin
                    if (out_ready && !last_b) begin
                        b       <= b + BW'(1);
                        best_ok <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PBVI_VALUE_SAT_EN
    logic signed [ACC_W-1:0] val_shr;
    logic                    val_fits;

    assign val_shr  = best_val >>> W;
    assign val_fits = (&val_shr[ACC_W-1:W-1]) || !(|val_shr[ACC_W-1:W-1]);
    assign out_value = val_fits ? val_shr[W-1:0]
                                : {val_shr[ACC_W-1], {(W - 1){~val_shr[ACC_W-1]}}};
`else
    assign out_value = best_val;
`endif

endmodule

// File: tb/tb_pbvi_backup_select.sv
// Self-checking bench for pbvi_backup_select: directed vectors plus random
// belief/gamma data checked against a dot-product/argmax model.
module tb_pbvi_backup_select;

    localparam int NS = 2;
    localparam int NB = 16;
    localparam int NA = 3;
    localparam int W  = 16;
`ifdef PBVI_VALUE_SAT_EN
    localparam int VW = 16;
`else
    localparam int VW = 34;
`endif

    logic          clk, rst;
    logic          wr_en, wr_sel;
    logic [1:0]    wr_a;
    logic [3:0]    wr_b;
    logic [0:0]    wr_s;
    logic [W-1:0]  wr_data;
    logic          start, busy, done, out_valid, out_ready;
    logic [3:0]    out_b;
    logic [1:0]    out_action;
    logic [VW-1:0] out_value;

    pbvi_backup_select #(.NUM_S(NS), .NUM_B(NB), .NUM_A(NA), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_a       (wr_a),
        .wr_b       (wr_b),
        .wr_s       (wr_s),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_b      (out_b),
        .out_action (out_action),
        .out_value  (out_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bel0, bel1;
        logic [15:0] g00, g01, g10, g11, g20, g21;
        int          act;
        longint      val;
    } vec_t;

    vec_t vecs [7];

    logic [15:0] bel_m [NB][NS];
    logic [15:0] gam_m [NA][NB][NS];
    int          exp_act [NB];
    longint      exp_val [NB];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain dot products, first maximum wins.
    function automatic void model();
        for (int bi = 0; bi < NB; bi++) begin
            longint best;
            int     besta;
            best  = 0;
            besta = 0;
            for (int ai = 0; ai < NA; ai++) begin
                longint d;
                d = 0;
                for (int si = 0; si < NS; si++)
                    d += longint'(bel_m[bi][si]) * longint'($signed(gam_m[ai][bi][si]));
                if (ai == 0 || d > best) begin
                    best  = d;
                    besta = ai;
                end
            end
            exp_act[bi] = besta;
            exp_val[bi] = best;
        end
    endfunction

    function automatic logic [63:0] to_out(input longint v);
`ifdef PBVI_VALUE_SAT_EN
        longint q;
        q = v >>> 16;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return 64'(q) & 64'hFFFF;
`else
        return 64'(v) & ((64'd1 << 34) - 64'd1);
`endif
    endfunction

    task automatic wr(input bit sel, input int a, input int b, input int s,
                      input logic [15:0] d, input bit upd);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_a    = a[1:0];
        wr_b    = b[3:0];
        wr_s    = s[0:0];
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (upd) begin
            if (sel) gam_m[a][b][s] = d;
            else     bel_m[b][s] = d;
        end
    endtask

    task automatic sweep(input int n_exp, input bit use_tbl, input bit bp,
                         input bit guard, input bit cowrite, input logic [15:0] cw_data);
        int          n;
        int          ea;
        logic [63:0] ev;
        logic [63:0] cap;
        @(negedge clk);
        start = 1'b1;
        if (cowrite) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_a = 2'd0; wr_b = 4'd15; wr_s = 1'b1;
            wr_data = cw_data;
            bel_m[15][1] = cw_data;
        end
        model();
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
            start = guard && (n == 4);
            wr_en = guard && (n >= 2) && (n <= 6);
            if (guard) begin
                wr_sel = n[0]; wr_a = 2'd0; wr_b = n[3:0]; wr_s = 1'b0; wr_data = 16'hDEAD;
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        check("first_latency", 64'(n), 64'd10);
        for (int k = 0; k < n_exp; k++) begin
            if (k > 0) begin
                n = 0;
                while (!out_valid && n < 60) begin
                    @(negedge clk);
                    n++;
                end
                check("gap_latency", 64'(n), 64'd9);
            end
            ea = (use_tbl && k < 7) ? vecs[k].act : exp_act[k];
            ev = to_out((use_tbl && k < 7) ? vecs[k].val : exp_val[k]);
            check("out_valid", 64'(out_valid), 64'd1);
            check("out_b", 64'(out_b), 64'(k));
            check("out_action", 64'(out_action), 64'(ea));
            check("out_value", 64'(out_value), ev);
            check("no_early_done", 64'(done), 64'd0);
            if (bp && k == 0) begin
                cap = 64'({1'b1, out_b, out_action, out_value});
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold", 64'({out_valid, out_b, out_action, out_value}), cap);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        if (n_exp == NB) begin
            check("done_pulse", 64'(done), 64'd1);
            check("busy_in_fin", 64'(busy), 64'd0);
            @(negedge clk);
            check("done_once", 64'(done), 64'd0);
            check("idle_no_valid", 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_a = '0; wr_b = '0; wr_s = '0;
        wr_data = '0; start = 1'b0; out_ready = 1'b0;

        vecs[0] = '{16'h8000, 16'h8000, 16'h0100, 16'h0100, 16'h0200, 16'h0000,
                    16'h0000, 16'h0300, 2, 64'sh1800000};
        vecs[1] = '{16'h8000, 16'h8000, 16'h0100, 16'h0100, 16'h0200, 16'h0000,
                    16'h0080, 16'h0080, 0, 64'sh1000000};
        vecs[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                    16'hFFFF, 16'hFFFF, 0, -64'sd65535};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                    16'h7FFF, 16'h7FFF, 0, 64'shFFFD0002};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                    16'h8000, 16'h8000, 0, -64'shFFFF0000};
        vecs[5] = '{16'h4000, 16'hC000, 16'h1000, 16'hF000, 16'hE000, 16'h2000,
                    16'h0000, 16'h0000, 1, 64'sh10000000};
        vecs[6] = '{16'h0001, 16'h0000, 16'hFFFB, 16'h0000, 16'h0003, 16'h0007,
                    16'h0003, 16'h7FFF, 1, 64'sd3};

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_b", 64'(out_b), 64'd0);
        check("rst_out_action", 64'(out_action), 64'd0);
        check("rst_out_value", 64'(out_value), 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            wr(0, 0, k, 0, vecs[k].bel0, 1);
            wr(0, 0, k, 1, vecs[k].bel1, 1);
            wr(1, 0, k, 0, vecs[k].g00, 1);
            wr(1, 0, k, 1, vecs[k].g01, 1);
            wr(1, 1, k, 0, vecs[k].g10, 1);
            wr(1, 1, k, 1, vecs[k].g11, 1);
            wr(1, 2, k, 0, vecs[k].g20, 1);
            wr(1, 2, k, 1, vecs[k].g21, 1);
        end
        for (int k = 7; k < NB; k++) begin
            for (int s = 0; s < NS; s++) begin
                wr(0, 0, k, s, 16'($urandom), 1);
                for (int a = 0; a < NA; a++) wr(1, a, k, s, 16'($urandom), 1);
            end
        end

        // Directed vectors, backpressure on the first result.
        sweep(NB, 1, 1, 0, 0, 16'h0);
        // Writes and a stray start while busy must not disturb the sweep or memories.
        sweep(NB, 0, 0, 1, 0, 16'h0);
        sweep(NB, 0, 0, 0, 0, 16'h0);

        // Abort during MAC of b=3.
        sweep(3, 0, 0, 0, 0, 16'h0);
        @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sweep(NB, 1, 0, 0, 0, 16'h0);

        // Out-of-range action write is dropped; then start with a same-cycle write.
        wr(1, 3, 5, 0, 16'h1234, 0);
        sweep(NB, 0, 0, 0, 1, 16'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
